// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide control front end.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } md_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MD_LATENCY_DEFAULT = 34;
    localparam int MD_CNT_W           = 6;

endpackage

// File: rtl/multdiv_sequencer.sv
// Sequences one MULT/DIV through the iterative engine and commits Hi/Lo; done lands MD_LATENCY+2 cycles
// after acceptance; requests are not queued, op_req is only honoured in IDLE while stall holds the pipeline.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic        clock,
    input  logic        Reset_n,
    input  logic        op_req,
    input  logic        op_sel,
    input  logic [31:0] RegA_out,
    input  logic [31:0] RegB_out,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_ctrl,
    output logic        md_clr,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        md_dbz,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        stall,
    output logic        done,
    output logic        div_zero_exc
);

    if (MD_LATENCY < 1 || MD_LATENCY > 63) begin : g_latency_range
        $error("multdiv_sequencer: MD_LATENCY must be within 1..63");
    end

    localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_LATENCY - 1);

    md_state_t             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]           a_q, a_d, b_q, b_d;
    logic [31:0]           hi_q, hi_d, lo_q, lo_d;
    logic                  op_q, op_d;
    logic                  clr_q, clr_d;
    logic                  stall_q, stall_d;
    logic                  done_q, done_d;
    logic                  dze_q, dze_d;

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MULT;
            clr_q   <= 1'b0;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
            dze_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            clr_q   <= clr_d;
            stall_q <= stall_d;
            done_q  <= done_d;
            dze_q   <= dze_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        dze_d   = 1'b0;
        // stall drops the cycle after done; a fresh acceptance below re-arms it
        stall_d = done_q ? 1'b0 : stall_q;

        case (state_q)
            IDLE: begin
                if (op_req) begin
                    a_d     = RegA_out;
                    b_d     = RegB_out;
                    op_d    = op_sel;
                    clr_d   = 1'b1;
                    stall_d = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // divide-by-zero outranks latency expiry landing in the same cycle
                if (op_q == OP_DIV && md_dbz) begin
                    done_d  = 1'b1;
                    dze_d   = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    hi_d    = md_hi;
                    lo_d    = md_lo;
                    done_d  = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign md_a         = a_q;
    assign md_b         = b_q;
    assign md_ctrl      = op_q;
    assign md_clr       = clr_q;
    assign Hi           = hi_q;
    assign Lo           = lo_q;
    assign stall        = stall_q;
    assign done         = done_q;
    assign div_zero_exc = dze_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomised and directed bench for multdiv_sequencer against a cycle-offset transaction model.
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    localparam int LAT   = 34;
    localparam int LAT10 = 10;

    logic        clock    = 1'b0;
    logic        Reset_n  = 1'b1;
    logic        op_req   = 1'b0;
    logic        op_sel   = 1'b0;
    logic [31:0] RegA_out = '0;
    logic [31:0] RegB_out = '0;
    logic [31:0] md_a, md_b, md_hi, md_lo, Hi, Lo;
    logic        md_ctrl, md_clr, md_dbz, stall, done, div_zero_exc;

    logic        op_req10 = 1'b0;
    logic [31:0] md_a10, md_b10, Hi10, Lo10;
    logic        md_ctrl10, md_clr10, stall10, done10, dze10;

    int tests = 0;
    int fails = 0;

    multdiv_sequencer u_dut (
        .clock(clock), .Reset_n(Reset_n), .op_req(op_req), .op_sel(op_sel),
        .RegA_out(RegA_out), .RegB_out(RegB_out),
        .md_a(md_a), .md_b(md_b), .md_ctrl(md_ctrl), .md_clr(md_clr),
        .md_hi(md_hi), .md_lo(md_lo), .md_dbz(md_dbz),
        .Hi(Hi), .Lo(Lo), .stall(stall), .done(done), .div_zero_exc(div_zero_exc)
    );

    multdiv_sequencer #(.MD_LATENCY(LAT10)) u_dut10 (
        .clock(clock), .Reset_n(Reset_n), .op_req(op_req10), .op_sel(1'b0),
        .RegA_out(RegA_out), .RegB_out(RegB_out),
        .md_a(md_a10), .md_b(md_b10), .md_ctrl(md_ctrl10), .md_clr(md_clr10),
        .md_hi(32'hCAFE_F00D), .md_lo(32'h0BAD_BEEF), .md_dbz(1'b0),
        .Hi(Hi10), .Lo(Lo10), .stall(stall10), .done(done10), .div_zero_exc(dze10)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Engine behaviour: signed product, or {remainder, quotient}; x/0 yields {a, all-ones}.
    function automatic logic [63:0] eng_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic op, input bit fixed);
        logic signed [63:0] sa, sb, p;
        logic signed [31:0] da, db, q, r;
        if (fixed) return 64'h12345678_9ABCDEF0;
        if (op == OP_MULT) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            p  = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        da = a;
        db = b;
        q  = da / db;
        r  = da % db;
        return {r, q};
    endfunction

    // Engine stand-in: result valid only once LAT-1 edges have passed since the clear.
    int          e_cnt     = 63;
    bit          e_act     = 1'b0;
    int          dbz_delay = 100;
    bit          eng_fixed = 1'b0;
    logic [63:0] eng;

    always @(posedge clock) begin
        if (md_clr) begin
            e_cnt <= 0;
            e_act <= 1'b1;
        end else if (e_cnt < 63) begin
            e_cnt <= e_cnt + 1;
        end
    end

    assign eng    = eng_res(md_a, md_b, md_ctrl, eng_fixed);
    assign md_hi  = (e_cnt >= LAT - 1) ? eng[63:32] : (32'hDEAD_0000 | 32'(e_cnt));
    assign md_lo  = (e_cnt >= LAT - 1) ? eng[31:0]  : (32'hBEEF_0000 | 32'(e_cnt));
    assign md_dbz = e_act && md_ctrl && (md_b == 32'd0) && (e_cnt >= dbz_delay);

    // Transaction model: m_k counts cycles since acceptance (1 = clear cycle, LAT+2 = commit cycle).
    bit          m_busy = 1'b0, m_done = 1'b0, m_dze = 1'b0, nd, ndz;
    int          m_k = 0;
    logic [31:0] m_a, m_b, m_hi, m_lo;
    logic        m_op;
    logic [63:0] m_r;

    always @(negedge clock) begin
        if (!Reset_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_dze = 1'b0; m_k = 0;
            m_a = '0; m_b = '0; m_op = OP_MULT; m_hi = '0; m_lo = '0;
        end
        check("stall",   32'(stall),        32'(m_busy || m_done));
        check("done",    32'(done),         32'(m_done));
        check("div_exc", 32'(div_zero_exc), 32'(m_dze));
        check("md_clr",  32'(md_clr),       32'(m_busy && m_k == 1));
        check("md_ctrl", 32'(md_ctrl),      32'(m_op));
        check("md_a", md_a, m_a);
        check("md_b", md_b, m_b);
        check("Hi",   Hi,   m_hi);
        check("Lo",   Lo,   m_lo);
        if (Reset_n) begin
            nd  = 1'b0;
            ndz = 1'b0;
            if (!m_busy) begin
                if (op_req) begin
                    m_busy = 1'b1; m_k = 1;
                    m_a = RegA_out; m_b = RegB_out; m_op = op_sel;
                end
            end else if (m_k == LAT + 2) begin
                m_busy = 1'b0;
            end else if (m_k >= 2 && m_op == OP_DIV && md_dbz) begin
                m_busy = 1'b0; nd = 1'b1; ndz = 1'b1;
            end else if (m_k == LAT + 1) begin
                m_r  = eng_res(m_a, m_b, m_op, eng_fixed);
                m_hi = m_r[63:32];
                m_lo = m_r[31:0];
                nd   = 1'b1;
                m_k++;
            end else begin
                m_k++;
            end
            m_done = nd;
            m_dze  = ndz;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one op from an idle DUT; n = cycle of done counted from the acceptance cycle (0).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input bit garbage, output int n, output logic saw_dze);
        tick();
        op_req = 1'b1; RegA_out = a; RegB_out = b; op_sel = op;
        tick();
        op_req = 1'b0; RegA_out = $urandom; RegB_out = $urandom; op_sel = 1'($urandom);
        n = 1;
        while (!done && n < 200) begin
            if (garbage) op_req = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        op_req  = 1'b0;
        saw_dze = div_zero_exc;
        check("done_within_bound", 32'(n < 200), 32'd1);
    endtask

    int          n, d1, d2, clr_cnt, dly;
    logic        z, rop;
    logic [31:0] ra, rb;

    initial begin
        #2 Reset_n = 1'b0;
        repeat (3) tick();
        check("rst_Hi", Hi, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_md_clr", 32'(md_clr), 32'd0);
        Reset_n = 1'b1;

        run_op(32'd7, 32'hFFFF_FFFD, OP_MULT, 1'b0, n, z);
        check("mult_done_cycle", n, 32'd36);
        check("mult_Hi", Hi, 32'hFFFF_FFFF);
        check("mult_Lo", Lo, 32'hFFFF_FFEB);

        run_op(32'd100, 32'd7, OP_DIV, 1'b0, n, z);
        check("div_Lo", Lo, 32'd14);
        check("div_Hi", Hi, 32'd2);
        check("div_no_exc", 32'(z), 32'd0);

        eng_fixed = 1'b1;
        run_op($urandom, $urandom, OP_MULT, 1'b0, n, z);
        eng_fixed = 1'b0;
        check("preload_Hi", Hi, 32'h1234_5678);
        check("preload_Lo", Lo, 32'h9ABC_DEF0);

        dbz_delay = 0;
        run_op(32'd5, 32'd0, OP_DIV, 1'b0, n, z);
        check("dbz_done_cycle", n, 32'd3);
        check("dbz_exc", 32'(z), 32'd1);
        tick();
        check("dbz_Hi_kept", Hi, 32'h1234_5678);
        check("dbz_Lo_kept", Lo, 32'h9ABC_DEF0);

        dbz_delay = LAT - 1;
        run_op(32'd9, 32'd0, OP_DIV, 1'b0, n, z);
        check("dbz_prio_cycle", n, 32'd36);
        check("dbz_prio_exc", 32'(z), 32'd1);
        dbz_delay = 100;

        tick();
        op_req = 1'b1; RegA_out = 32'd3; RegB_out = 32'd4; op_sel = OP_MULT;
        tick();
        op_req = 1'b0;
        repeat (10) tick();
        #2 Reset_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_Hi", Hi, 32'd0);
        check("arst_Lo", Lo, 32'd0);
        check("arst_md_a", md_a, 32'd0);
        check("arst_done", 32'(done), 32'd0);
        repeat (2) tick();
        Reset_n = 1'b1;
        run_op(32'd6, 32'd7, OP_MULT, 1'b0, n, z);
        check("post_rst_cycle", n, 32'd36);
        check("post_rst_Lo", Lo, 32'd42);

        tick();
        op_req = 1'b1; RegA_out = 32'd11; RegB_out = 32'hFFFF_FFFE; op_sel = OP_MULT;
        n = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && n < 200) begin
            tick();
            n++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b_first_Lo", Lo, 32'hFFFF_FFEA);
                    RegA_out = 32'd5; RegB_out = 32'd6;
                end else begin
                    d2 = n;
                end
            end
        end
        op_req = 1'b0;
        check("b2b_first_done", d1, 32'd36);
        check("b2b_second_done", d2, 32'd73);
        check("b2b_second_Lo", Lo, 32'd30);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            if (rop == OP_DIV) rb = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 50000));
            else               rb = $urandom;
            dly       = $urandom_range(0, LAT + 4);
            dbz_delay = dly;
            run_op(ra, rb, rop, 1'b1, n, z);
            if (rop == OP_DIV && rb == 32'd0 && dly <= LAT - 1) begin
                check("rand_abort_cycle", n, 32'(dly + 3));
                check("rand_abort_exc", 32'(z), 32'd1);
            end else begin
                check("rand_done_cycle", n, 32'd36);
                check("rand_no_exc", 32'(z), 32'd0);
            end
        end
        dbz_delay = 100;

        tick();
        op_req10 = 1'b1; RegA_out = 32'h77;
        tick();
        op_req10 = 1'b0;
        n = 1; clr_cnt = 0;
        while (!done10 && n < 100) begin
            if (md_clr10) clr_cnt++;
            tick();
            n++;
        end
        check("lat10_done_cycle", n, 32'd12);
        check("lat10_clr_once", clr_cnt, 32'd1);
        check("lat10_md_a", md_a10, 32'h77);
        check("lat10_Hi", Hi10, 32'hCAFE_F00D);
        check("lat10_Lo", Lo10, 32'h0BAD_BEEF);
        check("lat10_stall_done", 32'(stall10), 32'd1);
        tick();
        check("lat10_stall_after", 32'(stall10), 32'd0);
        check("lat10_done_after", 32'(done10), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Control-side front end for the iterative multiply/divide engine. Accepts one MULT/DIV request from the CPU control unit and latches operands. Clears and drives the engine, stalls the pipeline for the engine's fixed latency, then commits the engine result into the architectural Hi/Lo registers. Divide-by-zero is reported as a one-cycle exception pulse with Hi/Lo left untouched.

## Interface
Parameters:
- MD_LATENCY, 34: RUN cycles after the engine clear until md_hi/md_lo are valid.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- op_req  in  1  control unit requests an operation; sampled only in IDLE.
- op_sel  in  1  0 = MULT (signed Booth), 1 = DIV (quotient→Lo, remainder→Hi).
- RegA_out  in  32  operand A (multiplicand / dividend).
- RegB_out  in  32  operand B (multiplier / divisor).
- md_a, md_b  out  32  latched operands to the engine; stable for the whole operation.
- md_ctrl  out  1  engine op select (MDControl); equals latched op_sel.
- md_clr  out  1  engine synchronous clear, active-high, one cycle.
- md_hi, md_lo  in  32  engine result outputs.
- md_dbz  in  1  engine divide-by-zero flag.
- Hi, Lo  out  32  architectural Hi/Lo registers.
- stall  out  1  pipeline hold while an operation is in flight.
- done  out  1  one-cycle pulse when the operation ends (commit or abort).
- div_zero_exc  out  1  one-cycle pulse when a DIV aborts on divisor 0.

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE: stall=0, md_clr=0.
  - If op_req=1: latch md_a←RegA_out, md_b←RegB_out, op←op_sel. Go to CLEAR.
- CLEAR: md_clr=1 for exactly one cycle; cnt←0; go to RUN.
- RUN: md_clr=0; cnt increments each cycle.
  - If op=DIV and md_dbz=1: pulse done and div_zero_exc; Hi/Lo unchanged; go to IDLE.
  - Else if cnt==MD_LATENCY-1: go to CAPTURE.
- CAPTURE: Hi←md_hi, Lo←md_lo; pulse done; go to IDLE.
- cnt is 6 bits; it never wraps because MD_LATENCY≤63 is enforced by an elaboration check.
- op_req is ignored outside IDLE; there is no queuing.
- Divide-by-zero takes priority over latency expiry in the same cycle.

## Timing
- Reset (asynchronous, any state):
  - state=IDLE; Hi=Lo=0; md_a=md_b=0; md_ctrl=0; md_clr=0; stall=0; done=0; div_zero_exc=0; cnt=0.
- Reset mid-operation discards the operation; no done pulse is produced.
- Stall rules:
  - stall is registered; high from the cycle after op_req acceptance through the cycle in which done=1.
  - stall is low the following cycle.
- Normal latency: op_req edge (cycle 0) → CLEAR (cycle 1) → RUN cycles 2..MD_LATENCY+1 → CAPTURE at cycle MD_LATENCY+2.
  - Hi/Lo and done are visible after that edge.
  - Default: done high in cycle 36.
- DBZ abort: done and div_zero_exc are high the cycle after md_dbz is first seen high in RUN.
- Back-to-back: op_req held high in the done cycle is accepted on the next cycle, since that cycle is IDLE. Minimum issue spacing is MD_LATENCY+3 cycles.

## Structure
- Package multdiv_pkg:
  - state enum (IDLE, CLEAR, RUN, CAPTURE);
  - op codes OP_MULT=1'b0, OP_DIV=1'b1;
  - default MD_LATENCY.
- No sub-module. The FSM, counter, operand latches and Hi/Lo registers stay in one module; the engine is instantiated by the parent datapath.

## Test plan
- MULT 7 × −3 (0x00000007, 0xFFFFFFFD), behavioral engine model → Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; done at cycle 36; stall high in cycles 1–36.
- DIV 100 / 7 → Lo=14, Hi=2; div_zero_exc stays 0; md_a/md_b stay constant even though RegA_out/RegB_out change after acceptance.
- DIV 5 / 0, engine raises md_dbz in the first RUN cycle → done and div_zero_exc pulse at cycle 3; Hi/Lo keep their prior values (0x12345678/0x9ABCDEF0).
- Reset_n low at RUN cycle 10 of a MULT → all outputs are reset values immediately (asynchronous); no done pulse; the next op_req starts cleanly.
- op_req held high continuously for two MULTs → second operation accepted the cycle after the first done; op_req pulses during RUN are ignored.
- MD_LATENCY=10 override → done at cycle 12; md_clr is high exactly once per operation.
